// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: Moore FSM generating fetch/execute datapath strobes for register-register ALU instructions.
// Outputs are registered and decoded from the next state, so each strobe lines up exactly with its state.
module alu_op_sequencer #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 8,
  parameter int CNT_W       = 16
) (
  input  logic                i_clock,
  input  logic                i_resetn,
  input  logic                i_run,
  input  logic [DATA_W-1:0]   i_ir,
  input  logic                i_mem_ready,
  output logic                o_pc_out,
  output logic                o_zlow_out,
  output logic                o_mdr_out,
  output logic                o_mar_in,
  output logic                o_zin,
  output logic                o_pc_in,
  output logic                o_mdr_in,
  output logic                o_ir_in,
  output logic                o_yin,
  output logic                o_inc_pc,
  output logic                o_read,
  output logic [OPC_W-1:0]    o_alu_op,
  output logic [NUM_REGS-1:0] o_rin,
  output logic [NUM_REGS-1:0] o_rout,
  output logic                o_busy,
  output logic                o_halted,
  output logic                o_fault,
  output logic [CNT_W-1:0]    o_instr_count
);
  localparam int RF_W   = $clog2(NUM_REGS);
  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'h03);
  localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'h06);
  localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(5'h11);
  localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(5'h12);
  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'h1B);

  function automatic logic [2**RF_W-1:0] reg_mask();
    for (int i = 0; i < 2**RF_W; i++) reg_mask[i] = i < NUM_REGS;
  endfunction
  localparam logic [2**RF_W-1:0] REG_OK = reg_mask();

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_DEC, S_U3, S_U4, S_B3, S_B4, S_B5, S_HALT, S_FAULT
  } state_t;

  state_t              r_state, w_next;
  logic [WAIT_W-1:0]   r_wait, w_wait_inc;
  logic [OPC_W-1:0]    w_opc;
  logic [RF_W-1:0]     w_ra, w_rb, w_rc;
  logic                w_unary, w_binary, w_regs_ok, w_timeout, w_retire;
  logic                w_unused_ir;

  assign w_opc       = i_ir[DATA_W-1 -: OPC_W];
  assign w_ra        = i_ir[DATA_W-OPC_W-1 -: RF_W];
  assign w_rb        = i_ir[DATA_W-OPC_W-RF_W-1 -: RF_W];
  assign w_rc        = i_ir[DATA_W-OPC_W-2*RF_W-1 -: RF_W];
  assign w_unused_ir = ^i_ir[DATA_W-OPC_W-3*RF_W-1:0];
  assign w_unary     = (w_opc == OP_NEG) || (w_opc == OP_NOT);
  assign w_binary    = (w_opc >= OP_ADD) && (w_opc <= OP_OR);
  assign w_regs_ok   = REG_OK[w_ra] && REG_OK[w_rb] && (w_unary || REG_OK[w_rc]);
  assign w_wait_inc  = r_wait + 1'b1;
  assign w_timeout   = !i_mem_ready && (w_wait_inc == WAIT_W'(MEM_TIMEOUT));
  assign w_retire    = (r_state == S_U4) || (r_state == S_B5) || (r_state == S_DEC && w_next == S_HALT);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       w_next = i_run ? S_T0 : S_IDLE;
      S_T0:         w_next = S_T1;
      S_T1:         w_next = i_mem_ready ? S_T2 : w_timeout ? S_FAULT : S_T1;
      S_T2:         w_next = S_DEC;
      S_DEC:        w_next = (w_opc == OP_HALT) ? S_HALT :
                             !(w_regs_ok && (w_unary || w_binary)) ? S_FAULT :
                             w_unary ? S_U3 : S_B3;
      S_U3:         w_next = S_U4;
      S_B3:         w_next = S_B4;
      S_B4:         w_next = S_B5;
      S_U4, S_B5:   w_next = i_run ? S_T0 : S_IDLE;
      S_HALT:       w_next = i_run ? S_HALT : S_IDLE;
      default:      w_next = S_FAULT;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_resetn) begin
    if (!i_resetn) begin
      r_state       <= S_IDLE;
      r_wait        <= '0;
      o_pc_out      <= 1'b0;
      o_zlow_out    <= 1'b0;
      o_mdr_out     <= 1'b0;
      o_mar_in      <= 1'b0;
      o_zin         <= 1'b0;
      o_pc_in       <= 1'b0;
      o_mdr_in      <= 1'b0;
      o_ir_in       <= 1'b0;
      o_yin         <= 1'b0;
      o_inc_pc      <= 1'b0;
      o_read        <= 1'b0;
      o_alu_op      <= '0;
      o_rin         <= '0;
      o_rout        <= '0;
      o_busy        <= 1'b0;
      o_halted      <= 1'b0;
      o_fault       <= 1'b0;
      o_instr_count <= '0;
    end else begin
      r_state       <= w_next;
      r_wait        <= (r_state == S_T1 && w_next == S_T1) ? w_wait_inc : '0;
      o_pc_out      <= w_next == S_T0;
      o_mar_in      <= w_next == S_T0;
      o_inc_pc      <= w_next == S_T0;
      o_zin         <= w_next == S_T0 || w_next == S_U3 || w_next == S_B4;
      // PC reload and Z drive only on the T0->T1 entry, not while stalled on memory
      o_pc_in       <= w_next == S_T1 && r_state == S_T0;
      o_zlow_out    <= (w_next == S_T1 && r_state == S_T0) || w_next == S_U4 || w_next == S_B5;
      o_read        <= w_next == S_T1;
      o_mdr_in      <= w_next == S_T1;
      o_mdr_out     <= w_next == S_T2;
      o_ir_in       <= w_next == S_T2;
      o_yin         <= w_next == S_B3;
      o_alu_op      <= (w_next == S_U3 || w_next == S_B4) ? w_opc : '0;
      o_rin         <= (w_next == S_U4 || w_next == S_B5) ? NUM_REGS'(1) << w_ra : '0;
      o_rout        <= (w_next == S_U3 || w_next == S_B3) ? NUM_REGS'(1) << w_rb :
                       (w_next == S_B4) ? NUM_REGS'(1) << w_rc : '0;
      o_busy        <= !(w_next == S_IDLE || w_next == S_HALT || w_next == S_FAULT);
      o_halted      <= w_next == S_HALT;
      o_fault       <= w_next == S_FAULT;
      o_instr_count <= (w_retire && !(&o_instr_count)) ? o_instr_count + 1'b1 : o_instr_count;
    end
  end
endmodule
